// File: rtl/axis_cmd_rx.sv
// AXI-Stream byte command receiver for ODIN programming, config bits and buffered AER events.
// Optional AXIS_RX_TLAST_CHECK_EN enforces tlast framing on every command.
module axis_cmd_rx #(
    parameter int AER_W       = 10,
    parameter int CFG_N       = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic                          CTRL_PROG_EVENT,
    output logic [15:0]                   CTRL_SPI_ADDR,
    output logic [1:0]                    CTRL_OP_CODE,
    output logic [15:0]                   CTRL_PROG_DATA,
    output logic [CFG_N-1:0]              CFG_REGS,
    output logic [AER_W-1:0]              AERIN_ADDR,
    output logic                          AERIN_REQ,
    input  logic                          AERIN_ACK,
    output logic [$clog2(FIFO_DEPTH):0]   AER_FIFO_LEVEL,
    output logic [7:0]                    ERR_CNT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, RECV, ISSUE} state_t;
    typedef enum logic [1:0] {K_SYN, K_NEU, K_AER, K_CFG} kind_t;

    state_t state, state_n;
    kind_t kind, hd_kind;
    logic hd_ok;
    logic [6:0] hdr;
    logic [15:0] sh;
    logic [1:0] cnt;
    logic [TW-1:0] tmo;
    logic acc, fin, err, full, tmo_hit, cfg_ok, push, pop;
    logic [AER_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;

`ifndef AXIS_RX_TLAST_CHECK_EN
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
`endif

    assign acc     = s_axis_tvalid & s_axis_tready;
    assign full    = (AER_FIFO_LEVEL == LW'(FIFO_DEPTH));
    assign tmo_hit = (tmo == TW'(TIMEOUT_CYC - 1));
    assign cfg_ok  = ({30'd0, hdr[3:2]} < CFG_N);
    assign push    = (state == ISSUE) && (kind == K_AER);
    assign pop     = !AERIN_REQ && !AERIN_ACK && (AER_FIFO_LEVEL != '0);

    always_comb begin
        hd_kind = K_SYN;
        hd_ok   = 1'b1;
        casez (s_axis_tdata[7:4])
            4'b1???: hd_kind = K_SYN;
            4'b0100: hd_kind = K_NEU;
            4'b0010: hd_kind = K_AER;
            4'b0001: hd_kind = K_CFG;
            default: hd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n       = state;
        s_axis_tready = 1'b0;
        err           = 1'b0;
        fin           = 1'b0;
        unique case (state)
            IDLE: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    if (!hd_ok) begin
                        err = 1'b1;
                    end else if (hd_kind == K_CFG) begin
`ifdef AXIS_RX_TLAST_CHECK_EN
                        if (!s_axis_tlast) err = 1'b1;
                        else               state_n = ISSUE;
`else
                        state_n = ISSUE;
`endif
                    end else begin
`ifdef AXIS_RX_TLAST_CHECK_EN
                        if (s_axis_tlast) err = 1'b1;
                        else              state_n = RECV;
`else
                        state_n = RECV;
`endif
                    end
                end
            end
            RECV: begin
                // stall the final AER byte so the event always has a slot
                s_axis_tready = !((kind == K_AER) && full);
                if (acc) begin
                    if (cnt == 2'd1) begin
`ifdef AXIS_RX_TLAST_CHECK_EN
                        if (!s_axis_tlast) begin
                            err     = 1'b1;
                            state_n = IDLE;
                        end else begin
                            fin     = 1'b1;
                            state_n = ISSUE;
                        end
`else
                        fin     = 1'b1;
                        state_n = ISSUE;
`endif
                    end else begin
`ifdef AXIS_RX_TLAST_CHECK_EN
                        if (s_axis_tlast) begin
                            err     = 1'b1;
                            state_n = IDLE;
                        end
`endif
                    end
                end else if (tmo_hit) begin
                    err     = 1'b1;
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                state_n = IDLE;
                if ((kind == K_CFG) && !cfg_ok) err = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= AER_W'({hdr[3:0], sh[7:0]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr             <= '0;
            kind            <= K_SYN;
            sh              <= '0;
            cnt             <= '0;
            tmo             <= '0;
            CTRL_PROG_EVENT <= 1'b0;
            CTRL_SPI_ADDR   <= '0;
            CTRL_OP_CODE    <= '0;
            CTRL_PROG_DATA  <= '0;
            CFG_REGS        <= '0;
            ERR_CNT         <= '0;
            wp              <= '0;
            rp              <= '0;
            AER_FIFO_LEVEL  <= '0;
            AERIN_REQ       <= 1'b0;
            AERIN_ADDR      <= '0;
        end else begin
            CTRL_PROG_EVENT <= 1'b0;
            if ((state == IDLE) && acc) begin
                hdr  <= s_axis_tdata[6:0];
                kind <= hd_kind;
                if ((hd_kind == K_SYN) || (hd_kind == K_NEU)) cnt <= 2'd3;
                else if (hd_kind == K_AER)                    cnt <= 2'd1;
                else                                          cnt <= 2'd0;
            end
            if ((state == RECV) && acc) begin
                sh  <= {sh[7:0], s_axis_tdata};
                cnt <= cnt - 2'd1;
            end
            if ((state == RECV) && !acc) tmo <= tmo + 1'b1;
            else                         tmo <= '0;
            if (fin && (kind == K_SYN || kind == K_NEU)) begin
                CTRL_PROG_EVENT <= 1'b1;
                CTRL_PROG_DATA  <= {sh[7:0], s_axis_tdata};
                if (kind == K_SYN) begin
                    CTRL_SPI_ADDR <= {2'b00, hdr, sh[15:8]};
                    CTRL_OP_CODE  <= 2'b10;
                end else begin
                    CTRL_SPI_ADDR <= {6'd0, hdr[1:0], sh[15:8]};
                    CTRL_OP_CODE  <= 2'b01;
                end
            end
            if ((state == ISSUE) && (kind == K_CFG) && cfg_ok) begin
                for (int i = 0; i < CFG_N; i++)
                    if (hdr[3:2] == 2'(i)) CFG_REGS[i] <= hdr[0];
            end
            if (err && (ERR_CNT != 8'hFF)) ERR_CNT <= ERR_CNT + 8'd1;
            if (push) wp <= wp + 1'b1;
            AER_FIFO_LEVEL <= AER_FIFO_LEVEL + LW'(push) - LW'(pop);
            // head moves into the output register as REQ rises
            if (pop) begin
                AERIN_REQ  <= 1'b1;
                AERIN_ADDR <= mem[rp];
                rp         <= rp + 1'b1;
            end else if (AERIN_REQ && AERIN_ACK) begin
                AERIN_REQ <= 1'b0;
            end
        end
    end
endmodule
